// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings and defaults for the data memory access unit
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEF_MEM_BYTES = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_SETUP,
        ST_WR,
        ST_RESP
    } state_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// rtl/mem_lane_fmt.sv - big-endian lane extract (load) and lane merge (store RMW)
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_extract,
    output logic [31:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte    = 8'h00;
        w_half    = i_offset[1] ? i_word[15:0] : i_word[31:16];
        o_extract = i_word;
        o_merge   = i_word;
        case (i_offset)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        case (i_size)
            SZ_BYTE: begin
                o_extract = {{24{~i_unsigned & w_byte[7]}}, w_byte};
                case (i_offset)
                    2'd0:    o_merge[31:24] = i_wdata[7:0];
                    2'd1:    o_merge[23:16] = i_wdata[7:0];
                    2'd2:    o_merge[15:8]  = i_wdata[7:0];
                    default: o_merge[7:0]   = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                o_extract = {{16{~i_unsigned & w_half[15]}}, w_half};
                if (i_offset[1]) o_merge[15:0]  = i_wdata;
                else             o_merge[31:16] = i_wdata;
            end
            default: begin
                o_extract = i_word;
                o_merge   = i_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer with alignment/range checks and sub-word RMW
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_addr,
    output logic        ram_rw,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_t      r_state;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_uns;
    logic        r_we;
    logic [15:0] r_wdata;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;
    logic [31:0] r_ram_addr;
    logic        r_ram_rw;
    logic [31:0] r_ram_wdata;

    logic [31:0] w_aligned;
    logic        w_err;
    logic [31:0] w_extract;
    logic [31:0] w_merge;

    assign w_aligned = {req_addr[31:2], 2'b00};
    // Range test done in 33 bits so addresses near 2^32 cannot wrap into range.
    assign w_err = (req_size == 2'b11)
                 | ((req_size == SZ_HALF) & req_addr[0])
                 | ((req_size == SZ_WORD) & (|req_addr[1:0]))
                 | (({1'b0, w_aligned} + 33'd3) >= 33'(MEM_BYTES));

    mem_lane_fmt u_lane_fmt (
        .i_word     (ram_rdata),
        .i_offset   (r_off),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_wdata    (r_wdata),
        .o_extract  (w_extract),
        .o_merge    (w_merge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_off        <= 2'd0;
            r_size       <= 2'd0;
            r_uns        <= 1'b0;
            r_we         <= 1'b0;
            r_wdata      <= 16'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_ram_addr   <= 32'd0;
            r_ram_rw     <= 1'b0;
            r_ram_wdata  <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (w_err) begin
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'd0;
                            r_resp_valid <= 1'b1;
                            r_state      <= ST_RESP;
                        end else begin
                            r_ram_addr <= w_aligned;
                            r_off      <= req_addr[1:0];
                            r_size     <= req_size;
                            r_uns      <= req_unsigned;
                            r_we       <= req_we;
                            r_wdata    <= req_wdata[15:0];
                            if (req_we && req_size == SZ_WORD) begin
                                r_ram_wdata <= req_wdata;
                                r_state     <= ST_SETUP;
                            end else begin
                                r_state <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (r_we) begin
                        r_ram_wdata <= w_merge;
                        r_state     <= ST_SETUP;
                    end else begin
                        r_resp_rdata <= w_extract;
                        r_resp_err   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_SETUP: begin
                    r_ram_rw <= 1'b1;
                    r_state  <= ST_WR;
                end
                ST_WR: begin
                    r_ram_rw     <= 1'b0;
                    r_resp_rdata <= 32'd0;
                    r_resp_err   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign ram_addr   = r_ram_addr;
    assign ram_rw     = r_ram_rw;
    assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a byte-array model
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int MEMB = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_addr;
    logic        ram_rw;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    mem_access_unit #(.MEM_BYTES(MEMB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_addr     (ram_addr),
        .ram_rw       (ram_rw),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    // Level-sensitive RAM seen by the DUT, plus an independent byte-level reference memory.
    logic [7:0] ram [0:MEMB-1];
    logic [7:0] ref_mem [0:MEMB-1];
    logic [5:0] ba;
    assign ba = {ram_addr[5:2], 2'b00};
    assign ram_rdata = {ram[ba], ram[ba + 6'd1], ram[ba + 6'd2], ram[ba + 6'd3]};

    always @(posedge clk) begin
        if (ram_rw) begin
            ram[ba]        <= ram_wdata[31:24];
            ram[ba + 6'd1] <= ram_wdata[23:16];
            ram[ba + 6'd2] <= ram_wdata[15:8];
            ram[ba + 6'd3] <= ram_wdata[7:0];
        end
    end

    int          wr_cycles = 0;
    int          resp_count = 0;
    int          glitches = 0;
    logic [31:0] last_wr_addr = 32'd0;
    logic        prev_rw = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] prev_wdata = 32'd0;

    always @(negedge clk) begin
        if (ram_rw) begin
            wr_cycles    = wr_cycles + 1;
            last_wr_addr = ram_addr;
        end
        if (ram_rw !== prev_rw && (ram_addr !== prev_addr || ram_wdata !== prev_wdata))
            glitches = glitches + 1;
        prev_rw    = ram_rw;
        prev_addr  = ram_addr;
        prev_wdata = ram_wdata;
        if (resp_valid) resp_count = resp_count + 1;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wrs;
    } exp_t;

    function automatic exp_t model(input logic we, input logic [1:0] sz, input logic uns,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t   m;
        int     n;
        int     base;
        longint lv;
        logic [31:0] v;
        m.rdata = 32'd0;
        m.lat   = 0;
        m.wrs   = 0;
        m.err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
             || (((longint'(a) / 4) * 4 + 3) >= MEMB);
        if (m.err) return m;
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base = int'(a[5:0]);
        if (!we) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[base + i]);
            lv = longint'(v);
            if (!uns && n < 4 && v[8 * n - 1]) lv = lv - (longint'(1) << (8 * n));
            m.rdata = lv[31:0];
            m.lat   = 1;
        end else begin
            for (int i = 0; i < n; i++) ref_mem[base + i] = 8'(wd >> (8 * (n - 1 - i)));
            m.lat = (n == 4) ? 2 : 3;
            m.wrs = 1;
        end
        return m;
    endfunction

    task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat, output int wrs);
        int w0;
        rd  = 32'hDEAD_BEEF;
        err = 1'bx;
        lat = -1;
        @(negedge clk);
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        w0 = wr_cycles;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (resp_valid) begin
                lat = k; rd = resp_rdata; err = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat < 0) chk("resp_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        wrs = wr_cycles - w0;
    endtask

    task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_const, input bit use_const);
        exp_t        e;
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          wrs;
        e = model(we, sz, uns, a, wd);
        run(we, sz, uns, a, wd, rd, err, lat, wrs);
        chk({tag, "_rdata"}, rd, use_const ? exp_const : e.rdata);
        chk({tag, "_err"}, 32'(err), 32'(e.err));
        chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
        chk({tag, "_wr"}, 32'(wrs), 32'(e.wrs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        exp_t        q[$];
        int          sent;
        int          rcv;
        int          rc0;
        int          w0;
        int          bad;
        logic [7:0]  b;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] a;

        for (int i = 0; i < MEMB; i++) begin
            b = 8'($urandom);
            ram[i] = b;
            ref_mem[i] = b;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_rw", 32'(ram_rw), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        op("sw8", 1, SZ_WORD, 0, 32'd8, 32'h1122_3344, 32'd0, 1);
        chk("sw8_wr_addr", last_wr_addr, 32'd8);
        chk("sw8_ram", {ram[8], ram[9], ram[10], ram[11]}, 32'h1122_3344);
        op("lw8", 0, SZ_WORD, 0, 32'd8, 32'd0, 32'h1122_3344, 1);
        op("sb10", 1, SZ_BYTE, 0, 32'd10, 32'h0000_00AB, 32'd0, 1);
        op("lw8b", 0, SZ_WORD, 0, 32'd8, 32'd0, 32'h1122_AB44, 1);
        op("lbu9", 0, SZ_BYTE, 1, 32'd9, 32'd0, 32'h0000_0022, 1);
        op("sb12", 1, SZ_BYTE, 0, 32'd12, 32'h0000_0080, 32'd0, 1);
        op("lb12", 0, SZ_BYTE, 0, 32'd12, 32'd0, 32'hFFFF_FF80, 1);
        op("lbu12", 0, SZ_BYTE, 1, 32'd12, 32'd0, 32'h0000_0080, 1);
        op("sh14", 1, SZ_HALF, 0, 32'd14, 32'h0000_BEEF, 32'd0, 1);
        op("lh14", 0, SZ_HALF, 0, 32'd14, 32'd0, 32'hFFFF_BEEF, 1);
        op("lhu14", 0, SZ_HALF, 1, 32'd14, 32'd0, 32'h0000_BEEF, 1);
        op("lw12", 0, SZ_WORD, 0, 32'd12, 32'd0, 32'd0, 0);

        op("err_lw6", 0, SZ_WORD, 0, 32'd6, 32'd0, 32'd0, 1);
        op("err_lh5", 0, SZ_HALF, 0, 32'd5, 32'd0, 32'd0, 1);
        op("err_lw64", 0, SZ_WORD, 0, 32'd64, 32'd0, 32'd0, 1);
        op("err_sz11", 0, 2'b11, 0, 32'd0, 32'd0, 32'd0, 1);
        op("err_sw_hi", 1, SZ_WORD, 0, 32'hFFFF_FFFC, 32'h1234_5678, 32'd0, 1);

        // Abort a sub-word store in SETUP: nothing may reach the RAM or the response port.
        for (int i = 20; i < 24; i++) begin
            ram[i] = 8'hA5;
            ref_mem[i] = 8'hA5;
        end
        @(negedge clk);
        req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
        req_addr = 32'd20; req_wdata = 32'h0000_003C; req_valid = 1'b1;
        w0  = wr_cycles;
        rc0 = resp_count;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_rw", 32'(ram_rw), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_resp", 32'(resp_count - rc0), 32'd0);
        chk("abort_no_write", 32'(wr_cycles - w0), 32'd0);
        chk("abort_ready_after", 32'(req_ready), 32'd1);
        op("lw20", 0, SZ_WORD, 0, 32'd20, 32'd0, 32'hA5A5_A5A5, 1);

        // Back-to-back random traffic with req_valid held high; inputs scrambled while busy.
        sent = 0;
        rcv  = 0;
        rc0  = resp_count;
        for (int cyc = 0; cyc < 4000 && rcv < 40; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("b2b_extra_resp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("b2b_rdata", resp_rdata, e.rdata);
                    chk("b2b_err", 32'(resp_err), 32'(e.err));
                end
                rcv++;
            end
            if (req_ready) begin
                if (sent < 40) begin
                    we = 1'($urandom);
                    sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                    a  = 32'($urandom_range(0, MEMB + 7));
                    if ($urandom_range(0, 3) != 0) begin
                        if (sz == SZ_HALF) a[0] = 1'b0;
                        if (sz == SZ_WORD) a[1:0] = 2'b00;
                    end
                    req_we = we; req_size = sz; req_unsigned = 1'($urandom);
                    req_addr = a; req_wdata = $urandom; req_valid = 1'b1;
                    q.push_back(model(we, sz, req_unsigned, a, req_wdata));
                    sent++;
                end else begin
                    req_valid = 1'b0;
                end
            end else begin
                req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_resp_count", 32'(rcv), 32'd40);
        chk("b2b_pulses", 32'(resp_count - rc0), 32'd40);

        bad = 0;
        for (int i = 0; i < MEMB; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("final_mem", 32'(bad), 32'd0);
        chk("ram_port_stable", 32'(glitches), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
